// File: rtl/explosion_sequencer_if.sv
// Explosion sequencer bus: game-logic trigger, VGA counters, sprite ROM and
// palette-side pixel outputs.
interface explosion_sequencer_if #(
    parameter int ADDR_W = 13
);
    logic              frame_tick;
    logic              trigger;
    logic [9:0]        trig_x;
    logic [9:0]        trig_y;
    logic              abort;
    logic [9:0]        draw_x;
    logic [9:0]        draw_y;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_index;
    logic [3:0]        pix_index;
    logic              pix_valid;
    logic              busy;
    logic [2:0]        frame_idx;
    logic              done;

    modport slave (
        input  frame_tick, trigger, trig_x, trig_y, abort,
        input  draw_x, draw_y, rom_index,
        output rom_addr, pix_index, pix_valid, busy, frame_idx, done
    );

    modport master (
        output frame_tick, trigger, trig_x, trig_y, abort,
        output draw_x, draw_y, rom_index,
        input  rom_addr, pix_index, pix_valid, busy, frame_idx, done
    );
endinterface

// File: rtl/explosion_sequencer.sv
// Tank explosion sprite sequencer: frame-boundary animation, ROM addressing.
// Build option EXPLOSION_RETRIGGER_EN: trigger while busy restarts the run.
module explosion_sequencer #(
    parameter int NUM_FRAMES  = 5,
    parameter int HOLD_FRAMES = 4,
    parameter int SPRITE_W    = 32,
    parameter int SPRITE_H    = 32,
    parameter int ADDR_W      = 13,
    parameter int TRANSP_IDX  = 2
) (
    input logic                   clk,
    input logic                   reset_n,
    explosion_sequencer_if.slave  bus
);
    localparam int LOG_W = $clog2(SPRITE_W);
    localparam int LOG_H = $clog2(SPRITE_H);
    localparam int FR_SH = LOG_W + LOG_H;
    localparam int HC_W  = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(HOLD_FRAMES - 1);
    localparam logic [2:0]      LAST_FR  = 3'(NUM_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        PLAY = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [2:0]        frame_q, frame_n;
    logic [HC_W-1:0]   hold_q, hold_n;
    logic [9:0]        pos_x, pos_x_n;
    logic [9:0]        pos_y, pos_y_n;
    logic              done_q, done_n;
    logic              in_box, in_box_q;
    logic              retrig;
    logic [10:0]       x_end, y_end;
    logic [9:0]        dx, dy;
    logic [ADDR_W-1:0] addr_full;

`ifdef EXPLOSION_RETRIGGER_EN
    assign retrig = bus.trigger && (state != IDLE);
`else
    assign retrig = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            frame_q  <= '0;
            hold_q   <= '0;
            pos_x    <= '0;
            pos_y    <= '0;
            done_q   <= 1'b0;
            in_box_q <= 1'b0;
        end else begin
            state    <= state_n;
            frame_q  <= frame_n;
            hold_q   <= hold_n;
            pos_x    <= pos_x_n;
            pos_y    <= pos_y_n;
            done_q   <= done_n;
            in_box_q <= in_box;
        end
    end

    // abort beats a restart, which beats normal sequencing
    always_comb begin
        state_n = state;
        frame_n = frame_q;
        hold_n  = hold_q;
        pos_x_n = pos_x;
        pos_y_n = pos_y;
        done_n  = 1'b0;
        if (bus.abort) begin
            state_n = IDLE;
            frame_n = '0;
            hold_n  = '0;
        end else if (retrig) begin
            state_n = ARM;
            frame_n = '0;
            hold_n  = '0;
            pos_x_n = bus.trig_x;
            pos_y_n = bus.trig_y;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.trigger) begin
                        state_n = ARM;
                        pos_x_n = bus.trig_x;
                        pos_y_n = bus.trig_y;
                    end
                end
                ARM: begin
                    if (bus.frame_tick) begin
                        state_n = PLAY;
                        frame_n = '0;
                        hold_n  = '0;
                    end
                end
                PLAY: begin
                    if (bus.frame_tick) begin
                        if (hold_q < HOLD_MAX) begin
                            hold_n = hold_q + 1'b1;
                        end else begin
                            hold_n = '0;
                            if (frame_q == LAST_FR) begin
                                state_n = IDLE;
                                frame_n = '0;
                                done_n  = 1'b1;
                            end else begin
                                frame_n = frame_q + 3'd1;
                            end
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // 11-bit box edges so sprites near the right/bottom edge do not wrap
    assign x_end = {1'b0, pos_x} + 11'(SPRITE_W);
    assign y_end = {1'b0, pos_y} + 11'(SPRITE_H);

    assign in_box = (state == PLAY)
                 && (bus.draw_x >= pos_x)
                 && ({1'b0, bus.draw_x} < x_end)
                 && (bus.draw_y >= pos_y)
                 && ({1'b0, bus.draw_y} < y_end);

    assign dx = bus.draw_x - pos_x;
    assign dy = bus.draw_y - pos_y;

    assign addr_full = (ADDR_W'(frame_q) << FR_SH)
                     + (ADDR_W'(dy) << LOG_W)
                     + ADDR_W'(dx);

    assign bus.rom_addr  = in_box ? addr_full : '0;
    assign bus.pix_index = bus.rom_index;
    assign bus.pix_valid = in_box_q && (bus.rom_index != 4'(TRANSP_IDX));
    assign bus.busy      = (state != IDLE);
    assign bus.frame_idx = frame_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_explosion_sequencer.sv
// Scoreboard bench for explosion_sequencer: queued expectations checked by
// a negedge monitor on sampled outputs, done pulses and opaque pixels.
module tb_explosion_sequencer;
    localparam int ADDR_W = 13;

    localparam int S_BUSY  = 0;
    localparam int S_FRAME = 1;
    localparam int S_ADDR  = 2;
    localparam int S_PV    = 3;

    typedef struct packed {
        int cyc;
        int sel;
        int val;
    } samp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;

    samp_t sq[$];
    int    dq[$];
    int    pq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    explosion_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    explosion_sequencer #(
        .NUM_FRAMES (5),
        .HOLD_FRAMES(4),
        .SPRITE_W   (32),
        .SPRITE_H   (32),
        .ADDR_W     (ADDR_W),
        .TRANSP_IDX (2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    function automatic string sel_name(input int s);
        case (s)
            S_BUSY:  return "busy";
            S_FRAME: return "frame_idx";
            S_ADDR:  return "rom_addr";
            default: return "pix_valid";
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s @cyc %0d: got %0d expected %0d",
                      nm, cyc, act, exp);
    endtask

    always @(negedge clk) begin
        samp_t       s;
        logic [31:0] act;
        while (sq.size() > 0 && sq[0].cyc <= cyc) begin
            s = sq.pop_front();
            case (s.sel)
                S_BUSY:  act = 32'(bus.busy);
                S_FRAME: act = 32'(bus.frame_idx);
                S_ADDR:  act = 32'(bus.rom_addr);
                default: act = 32'(bus.pix_valid);
            endcase
            chk(sel_name(s.sel), act, s.val);
        end
        if (bus.done === 1'b1) begin
            chk("done_expected", 32'(dq.size() > 0), 1);
            if (dq.size() > 0) chk("done_cycle", cyc, dq.pop_front());
        end
        if (bus.pix_valid === 1'b1) begin
            chk("pix_expected", 32'(pq.size() > 0), 1);
            if (pq.size() > 0) chk("pix_index", 32'(bus.pix_index),
                                   pq.pop_front());
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ex(input int sel, input int val);
        sq.push_back('{cyc, sel, val});
    endtask

    task automatic ftick();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic fire(input int x, input int y);
        bus.trig_x  = 10'(x);
        bus.trig_y  = 10'(y);
        bus.trigger = 1'b1;
        step();
        bus.trigger = 1'b0;
    endtask

    task automatic draw(input int x, input int y);
        bus.draw_x = 10'(x);
        bus.draw_y = 10'(y);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        bus.frame_tick = 1'b0;
        bus.abort      = 1'b0;
        bus.rom_index  = 4'd7;
        draw(0, 0);
        fire(300, 300);
        bus.trigger = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            ex(S_BUSY, 0);
            ex(S_FRAME, 0);
            ex(S_PV, 0);
        end
        reset_n     = 1'b1;
        bus.trigger = 1'b0;
        step();
        ex(S_BUSY, 0);
        ex(S_FRAME, 0);
        ex(S_PV, 0);

        // full natural run with pixel probe during frame 2
        fire(100, 200);
        ex(S_BUSY, 1);
        ex(S_FRAME, 0);
        step(2);
        ex(S_BUSY, 1);
        for (int i = 1; i <= 21; i++) begin
            if (i == 21) dq.push_back(cyc + 1);
            ftick();
            ex(S_FRAME, (i == 21) ? 0 : (i - 1) / 4);
            ex(S_BUSY, (i < 21) ? 1 : 0);
            if (i == 9) begin
                draw(105, 203);
                bus.rom_index = 4'd2;
                ex(S_ADDR, 2149);
                step();
                bus.rom_index = 4'd7;
                pq.push_back(7);
                ex(S_PV, 1);
                step();
                bus.rom_index = 4'd2;
                ex(S_PV, 0);
                draw(0, 0);
                step();
                bus.rom_index = 4'd7;
                ex(S_PV, 0);
                ex(S_ADDR, 0);
                ex(S_FRAME, 2);
            end else begin
                step(2);
                ex(S_FRAME, (i == 21) ? 0 : (i - 1) / 4);
            end
        end
        step();
        ex(S_BUSY, 0);

        // screen-edge sprite, then abort on tick 9
        fire(1000, 470);
        ex(S_BUSY, 1);
        draw(1023, 470);
        ex(S_ADDR, 0);
        step();
        ex(S_PV, 0);
        ftick();
        ex(S_ADDR, 23);
        ex(S_PV, 0);
        step();
        pq.push_back(7);
        ex(S_PV, 1);
        draw(999, 470);
        ex(S_ADDR, 0);
        step();
        ex(S_PV, 0);
        draw(1023, 501);
        ex(S_ADDR, 1015);
        step();
        pq.push_back(7);
        ex(S_PV, 1);
        draw(1023, 502);
        ex(S_ADDR, 0);
        step();
        ex(S_PV, 0);
        draw(0, 0);
        for (int i = 2; i <= 9; i++) begin
            if (i == 9) bus.abort = 1'b1;
            ftick();
            bus.abort = 1'b0;
            ex(S_FRAME, (i == 9) ? 0 : (i - 1) / 4);
            ex(S_BUSY, (i == 9) ? 0 : 1);
            step();
        end
        step();
        ex(S_BUSY, 0);

        // trigger and abort together in IDLE
        bus.abort = 1'b1;
        fire(10, 10);
        bus.abort = 1'b0;
        ex(S_BUSY, 0);
        step();
        ex(S_BUSY, 0);

        // trigger during PLAY frame 3
        fire(100, 200);
        ex(S_BUSY, 1);
        for (int i = 1; i <= 13; i++) begin
            ftick();
            step();
        end
        ex(S_FRAME, 3);
        fire(50, 60);
`ifdef EXPLOSION_RETRIGGER_EN
        ex(S_BUSY, 1);
        ex(S_FRAME, 0);
        ftick();
        ex(S_FRAME, 0);
        draw(52, 61);
        ex(S_ADDR, 34);
`else
        ex(S_BUSY, 1);
        ex(S_FRAME, 3);
        ftick();
        ex(S_FRAME, 3);
        draw(105, 203);
        ex(S_ADDR, 3173);
`endif
        step();
        pq.push_back(7);
        ex(S_PV, 1);
        draw(0, 0);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        ex(S_BUSY, 0);
        ex(S_FRAME, 0);
        step(3);

        chk("samples_left", 32'(sq.size()), 0);
        chk("done_left", 32'(dq.size()), 0);
        chk("pix_left", 32'(pq.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/explosion_sequencer.md
Name: explosion_sequencer

Overview:
- Sequences the explosion sprite animation for a destroyed tank.
- On a trigger, it latches the hit position and steps through NUM_FRAMES explosion frames, advancing only on video-frame boundaries.
- Generates the sprite-ROM address for the current frame and pixel, and qualifies the returned 4-bit palette index for the 16-entry explosion palette.
- Sits between game logic (hit detection), the VGA pixel counters, the explosion sprite ROM, and the palette lookup.

Parameters:
- NUM_FRAMES, 5, number of explosion frames in the ROM, stored back-to-back.
- HOLD_FRAMES, 4, video frames each explosion frame is displayed (≥1).
- SPRITE_W, 32, sprite width in pixels (power of 2).
- SPRITE_H, 32, sprite height in pixels (power of 2).
- ADDR_W, 13, ROM address width; must satisfy 2^ADDR_W ≥ NUM_FRAMES*SPRITE_W*SPRITE_H.
- TRANSP_IDX, 2, palette index treated as transparent.

Ports:
- Clk  in  1  system/pixel clock.
- Reset_n  in  1  synchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame (start of vertical blank).
- trigger  in  1  start explosion (single-cycle pulse or level).
- trig_x  in  10  sprite top-left X, sampled with trigger.
- trig_y  in  10  sprite top-left Y, sampled with trigger.
- abort  in  1  cancel animation (e.g. game reset).
- draw_x  in  10  current pixel X from the VGA counter.
- draw_y  in  10  current pixel Y from the VGA counter.
- rom_addr  out  ADDR_W  sprite ROM address (combinational).
- rom_index  in  4  ROM data; valid one cycle after rom_addr.
- pix_index  out  4  palette index to the explosion palette.
- pix_valid  out  1  explosion pixel is opaque and visible this cycle.
- busy  out  1  sequencer not idle.
- frame_idx  out  3  current explosion frame.
- done  out  1  one-cycle pulse at natural completion.

Behaviour:
- Reset (Reset_n=0 at a Clk edge):
  - state=IDLE; frame_idx=0; hold_cnt=0; pos_x=pos_y=0.
  - in_box_q=0; done=0; busy=0; pix_valid=0.
- States: IDLE, ARM, PLAY.
- IDLE:
  - trigger=1 and abort=0 → latch trig_x/trig_y into pos_x/pos_y, go to ARM.
- ARM:
  - Waits so that frame 0 starts on a frame boundary.
  - On frame_tick → PLAY with frame_idx=0 and hold_cnt=0.
- PLAY, on each frame_tick:
  - If hold_cnt < HOLD_FRAMES-1, increment hold_cnt.
  - Else hold_cnt=0. If frame_idx==NUM_FRAMES-1, go to IDLE with done=1 for one cycle and frame_idx=0. Otherwise increment frame_idx.
- Timing: frame_idx never changes except on frame_tick, so there is no mid-frame tearing. Total visible duration is NUM_FRAMES*HOLD_FRAMES video frames after the arming tick.
- abort=1 in any state → next cycle state=IDLE, frame_idx=0, hold_cnt=0, no done pulse. abort has priority over trigger and frame_tick.
- trigger while in ARM or PLAY: ignored (see Optional Feature).
- busy = (state != IDLE).
- In-box test (combinational): in_box = (state==PLAY) && draw_x ≥ pos_x && draw_x < pos_x+SPRITE_W && draw_y ≥ pos_y && draw_y < pos_y+SPRITE_H.
  - Use 11-bit sums so the comparison is correct when pos_x+SPRITE_W exceeds 1023; no wrap.
- rom_addr = frame_idx*SPRITE_W*SPRITE_H + (draw_y-pos_y)*SPRITE_W + (draw_x-pos_x), truncated to ADDR_W.
  - Computed with shifts only.
  - When in_box=0 the value is don't-care but must be stable and deterministic; drive 0.
- Pixel latency:
  - in_box_q <= in_box each cycle.
  - pix_index = rom_index.
  - pix_valid = in_box_q && (rom_index != TRANSP_IDX).
  - This gives one-cycle alignment with the synchronous ROM.
- State exit: if the state leaves PLAY, in_box_q clears on the following cycle; no stale pixel survives beyond one cycle.

Optional Feature:
- Macro: EXPLOSION_RETRIGGER_EN.
- Defined: trigger (with abort=0) in ARM or PLAY re-latches trig_x/trig_y, resets frame_idx=0 and hold_cnt=0, and enters ARM. No done pulse is issued for the interrupted run.
- Undefined: trigger is ignored while busy=1.

Test Plan:
- Reset: hold Reset_n=0 for 3 cycles with trigger=1 → busy=0, frame_idx=0, pix_valid=0, done=0 throughout and on the first cycle after release.
- Full run: NUM_FRAMES=5, HOLD_FRAMES=4, trigger at (100,200), then 21 frame_ticks →
  - busy rises the next cycle.
  - frame_idx sequence 0,1,2,3,4, each held 4 ticks.
  - done pulses exactly once, the cycle after tick 21.
  - busy=0 afterwards.
- Pixel path: PLAY, frame_idx=2, pos=(100,200), draw=(105,203) → rom_addr=2*1024+3*32+5=2149. With rom_index=7 next cycle, pix_valid=1 and pix_index=7. With rom_index=2, pix_valid=0.
- Bounds: pos=(1000,470); draw_x=1023, draw_y=470 → in box. draw_x=999 → out of box. ARM state at any draw → pix_valid=0.
- Abort: abort at tick 9 of a run → IDLE next cycle, frame_idx=0, no done pulse. trigger and abort in the same cycle in IDLE → stays IDLE.
- Retrigger: trigger at (50,60) during PLAY frame 3 → with EXPLOSION_RETRIGGER_EN, ARM then frame 0 at (50,60). Without the macro, the run continues and the latched position is unchanged.
